// File: rtl/servo_ramp_pkg.sv
// Shared definitions for the two-channel servo position ramp: widths, FSM
// encoding, default frame length and the position clamp helper.
package servo_ramp_pkg;

  localparam int unsigned POS_W  = 12;
  localparam int unsigned STEP_W = 8;
  localparam int unsigned NUM_CH = 2;

  localparam int unsigned DATA_W = NUM_CH * POS_W;
  localparam int unsigned CFG_W  = NUM_CH * STEP_W;

  // 20 ms frame at a 50 MHz clock.
  localparam int unsigned DEFAULT_FRAME_DIV = 1000000;

  typedef logic [POS_W-1:0]  pos_t;
  typedef logic [STEP_W-1:0] step_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CH1  = 2'd1,
    ST_CH2  = 2'd2,
    ST_EMIT = 2'd3
  } state_e;

  function automatic pos_t clamp_pos(input pos_t value, input pos_t lo, input pos_t hi);
    if (value < lo) begin
      return lo;
    end
    if (value > hi) begin
      return hi;
    end
    return value;
  endfunction

endpackage

// File: rtl/servo_ramp_step.sv
// One ramp step for a single channel: moves cur toward target by at most
// step (step 0 snaps), never overshooting or wrapping.
module servo_ramp_step
  import servo_ramp_pkg::*;
(
  input  pos_t  cur_i,
  input  pos_t  target_i,
  input  step_t step_i,
  output pos_t  next_o,
  output logic  changed_o
);

  logic signed [POS_W:0] diff;
  logic        [POS_W:0] mag;
  logic        [POS_W:0] step_ext;
  pos_t                  step_pos;
  logic                  snap;

  always_comb begin
    // 13-bit signed difference so the full 0..4095 span keeps its sign.
    diff     = $signed({1'b0, target_i}) - $signed({1'b0, cur_i});
    mag      = diff[POS_W] ? $unsigned(-diff) : $unsigned(diff);
    step_ext = {{(POS_W + 1 - STEP_W){1'b0}}, step_i};
    step_pos = {{(POS_W - STEP_W){1'b0}}, step_i};
    snap     = (step_i == '0) || (mag <= step_ext);

    if (snap) begin
      next_o = target_i;
    end else if (diff[POS_W]) begin
      next_o = cur_i - step_pos;
    end else begin
      next_o = cur_i + step_pos;
    end

    changed_o = (next_o != cur_i);
  end

endmodule

// File: rtl/servo_ramp.sv
// Two-channel servo position ramp: once per frame each channel steps toward
// its target and a single out_wr strobe publishes the new positions.
module servo_ramp
  import servo_ramp_pkg::*;
#(
  parameter int unsigned FRAME_DIV = DEFAULT_FRAME_DIV,
  parameter int unsigned MIN_POS   = 0,
  parameter int unsigned MAX_POS   = 4095
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_wr,
  input  logic [CFG_W-1:0]  cfg_data,
  input  logic              cfg_wr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_wr,
  output logic [NUM_CH-1:0] at_target
);

  localparam int unsigned CNT_W = $clog2(FRAME_DIV);
  localparam pos_t        MIN_P = pos_t'(MIN_POS);
  localparam pos_t        MAX_P = pos_t'(MAX_POS);

  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_LAST = cnt_t'(FRAME_DIV - 1);

  cnt_t   cnt_q, cnt_d;
  logic   tick;
  state_e state_q, state_d;

  pos_t  [NUM_CH-1:0] tgt_q, tgt_d, in_tgt;
  step_t [NUM_CH-1:0] step_q, step_d;
  pos_t  [NUM_CH-1:0] snap_tgt_q, snap_tgt_d;
  step_t [NUM_CH-1:0] snap_step_q, snap_step_d;
  pos_t  [NUM_CH-1:0] cur_q, cur_d;

  logic              chg1_q, chg1_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_wr_q, out_wr_d;

  logic  ch_sel;
  pos_t  rs_cur, rs_tgt, rs_next;
  step_t rs_step;
  logic  rs_changed;

  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Host writes land in the live registers at any time; the snapshot is only
  // refreshed on the tick, taking a same-cycle write into account.
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      in_tgt[ch] = clamp_pos(in_data[ch*POS_W +: POS_W], MIN_P, MAX_P);
    end
    tgt_d       = in_wr  ? in_tgt   : tgt_q;
    step_d      = cfg_wr ? cfg_data : step_q;
    snap_tgt_d  = tick   ? tgt_d    : snap_tgt_q;
    snap_step_d = tick   ? step_d   : snap_step_q;
  end

  // The single step unit is shared: CH1 feeds channel 0, CH2 feeds channel 1.
  always_comb begin
    ch_sel  = (state_q == ST_CH2);
    rs_cur  = cur_q[ch_sel];
    rs_tgt  = snap_tgt_q[ch_sel];
    rs_step = snap_step_q[ch_sel];
  end

  servo_ramp_step u_step (
    .cur_i     (rs_cur),
    .target_i  (rs_tgt),
    .step_i    (rs_step),
    .next_o    (rs_next),
    .changed_o (rs_changed)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    chg1_d     = chg1_q;
    out_wr_d   = 1'b0;
    out_data_d = out_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d = ST_CH1;
        end
      end
      ST_CH1: begin
        cur_d[0] = rs_next;
        chg1_d   = rs_changed;
        state_d  = ST_CH2;
      end
      ST_CH2: begin
        cur_d[1] = rs_next;
        out_wr_d = chg1_q || rs_changed;
        if (out_wr_d) begin
          out_data_d = {rs_next, cur_q[0]};
        end
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      state_q     <= ST_IDLE;
      tgt_q       <= {NUM_CH{MIN_P}};
      step_q      <= '0;
      snap_tgt_q  <= {NUM_CH{MIN_P}};
      snap_step_q <= '0;
      cur_q       <= {NUM_CH{MIN_P}};
      chg1_q      <= 1'b0;
      out_data_q  <= {NUM_CH{MIN_P}};
      out_wr_q    <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      step_q      <= step_d;
      snap_tgt_q  <= snap_tgt_d;
      snap_step_q <= snap_step_d;
      cur_q       <= cur_d;
      chg1_q      <= chg1_d;
      out_data_q  <= out_data_d;
      out_wr_q    <= out_wr_d;
    end
  end

  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      at_target[ch] = (cur_q[ch] == tgt_q[ch]);
    end
  end

  assign out_data = out_data_q;
  assign out_wr   = out_wr_q;

endmodule

// File: tb/tb_servo_ramp.sv
// Bench for servo_ramp: two instances (full range and clamped range) run the
// same stimulus against a frame-level model of the ramp behaviour.
module tb_servo_ramp;

  localparam int FD = 100;
  localparam int MINP[2] = '{0, 500};
  localparam int MAXP[2] = '{4095, 2500};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [23:0] in_data = '0;
  logic        in_wr = 1'b0;
  logic [15:0] cfg_data = '0;
  logic        cfg_wr = 1'b0;

  logic [23:0] out_data0, out_data1;
  logic        out_wr0, out_wr1;
  logic [1:0]  at_target0, at_target1;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  servo_ramp #(.FRAME_DIV(FD), .MIN_POS(0), .MAX_POS(4095)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_wr(in_wr),
    .cfg_data(cfg_data), .cfg_wr(cfg_wr), .out_data(out_data0),
    .out_wr(out_wr0), .at_target(at_target0)
  );

  servo_ramp #(.FRAME_DIV(FD), .MIN_POS(500), .MAX_POS(2500)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_wr(in_wr),
    .cfg_data(cfg_data), .cfg_wr(cfg_wr), .out_data(out_data1),
    .out_wr(out_wr1), .at_target(at_target1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: positions, registers and the expected output strobe.
  int          m_cnt, m_age;
  int          m_cur[2][2], m_tgt[2][2], m_stp[2][2], m_nxt[2][2];
  bit          m_chg[2];
  bit          m_wr[2];
  logic [23:0] m_out[2];

  function automatic int clampm(input int i, input int v);
    if (v < MINP[i]) return MINP[i];
    if (v > MAXP[i]) return MAXP[i];
    return v;
  endfunction

  function automatic int approach(input int c, input int t, input int s);
    if (s == 0) return t;
    if (t > c) return (c + s < t) ? c + s : t;
    return (c - s > t) ? c - s : t;
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    m_age = -1;
    for (int i = 0; i < 2; i++) begin
      for (int ch = 0; ch < 2; ch++) begin
        m_cur[i][ch] = MINP[i];
        m_tgt[i][ch] = MINP[i];
        m_stp[i][ch] = 0;
        m_nxt[i][ch] = MINP[i];
      end
      m_chg[i] = 1'b0;
      m_wr[i]  = 1'b0;
      m_out[i] = {12'(MINP[i]), 12'(MINP[i])};
    end
  endtask

  task automatic model_edge();
    bit tick;
    int et, es;
    tick  = (m_cnt == FD - 1);
    m_cnt = tick ? 0 : m_cnt + 1;
    for (int i = 0; i < 2; i++) begin
      m_wr[i] = 1'b0;
      if (m_age == 0) m_cur[i][0] = m_nxt[i][0];
      if (m_age == 1) begin
        m_cur[i][1] = m_nxt[i][1];
        if (m_chg[i]) begin
          m_wr[i]  = 1'b1;
          m_out[i] = {12'(m_cur[i][1]), 12'(m_cur[i][0])};
        end
      end
      if (tick) begin
        m_chg[i] = 1'b0;
        for (int ch = 0; ch < 2; ch++) begin
          et = in_wr  ? clampm(i, int'(in_data[ch*12 +: 12])) : m_tgt[i][ch];
          es = cfg_wr ? int'(cfg_data[ch*8 +: 8]) : m_stp[i][ch];
          m_nxt[i][ch] = approach(m_cur[i][ch], et, es);
          if (m_nxt[i][ch] != m_cur[i][ch]) m_chg[i] = 1'b1;
        end
      end
      for (int ch = 0; ch < 2; ch++) begin
        if (in_wr)  m_tgt[i][ch] = clampm(i, int'(in_data[ch*12 +: 12]));
        if (cfg_wr) m_stp[i][ch] = int'(cfg_data[ch*8 +: 8]);
      end
    end
    m_age = tick ? 0 : ((m_age == 0 || m_age == 1) ? m_age + 1 : -1);
  endtask

  function automatic logic [1:0] m_at(input int i);
    return {m_cur[i][1] == m_tgt[i][1], m_cur[i][0] == m_tgt[i][0]};
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_edge();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("out_wr0",     32'(out_wr0),    32'(m_wr[0]));
      check("out_data0",   32'(out_data0),  32'(m_out[0]));
      check("at_target0",  32'(at_target0), 32'(m_at(0)));
      check("out_wr1",     32'(out_wr1),    32'(m_wr[1]));
      check("out_data1",   32'(out_data1),  32'(m_out[1]));
      check("at_target1",  32'(at_target1), 32'(m_at(1)));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic realign();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic do_in, input logic [23:0] d, input logic do_cfg, input logic [15:0] c);
    in_wr    = do_in;
    in_data  = d;
    cfg_wr   = do_cfg;
    cfg_data = c;
    realign();
    in_wr  = 1'b0;
    cfg_wr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    realign();
    realign();
    rst_n = 1'b1;
  endtask

  task automatic wait_age(input int k);
    int n = 0;
    do begin
      realign();
      n++;
    end while (m_age != k && n < 3 * FD);
  endtask

  // Returns at the falling edge where out_wr0 is seen high.
  task automatic wait_pulse(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (out_wr0 !== 1'b1 && n < 3 * FD);
    check({name, "_seen"}, 32'(out_wr0), 32'd1);
  endtask

  initial begin
    int pulses, n;
    #1 rst_n = 1'b0;
    realign();
    realign();
    rst_n = 1'b1;
    check("reset_out_data0", 32'(out_data0), 32'h0);
    check("reset_out_data1", 32'(out_data1), 32'h1F41F4);

    // Snap with zero steps.
    write(1'b1, {12'd200, 12'd1000}, 1'b0, 16'h0);
    wait_pulse("snap");
    check("snap_data", 32'(out_data0), 32'h0C83E8);
    check("snap_at",   32'(at_target0), 32'b11);
    realign();

    // Clamp on the 500..2500 instance.
    write(1'b1, {12'd700, 12'd2000}, 1'b0, 16'h0);
    wait_pulse("pre_clamp");
    realign();
    write(1'b1, 24'hFFF000, 1'b0, 16'h0);
    check("clamp_at_before", 32'(at_target1), 32'b00);
    wait_pulse("clamp");
    check("clamp_data", 32'(out_data1), 32'h9C41F4);
    check("clamp_at",   32'(at_target1), 32'b11);
    realign();

    // Ramp 0 -> 100 by 30.
    do_reset();
    write(1'b1, {12'd0, 12'd100}, 1'b1, {8'd0, 8'd30});
    foreach (MINP[k]) begin end
    for (int k = 1; k <= 4; k++) begin
      wait_pulse("ramp");
      check($sformatf("ramp_%0d", k), 32'(out_data0), 32'((k < 4) ? 30 * k : 100));
      realign();
    end
    pulses = 0;
    repeat (2 * FD) begin
      @(negedge clk);
      if (out_wr0 === 1'b1) pulses++;
    end
    check("ramp_quiet", 32'(pulses), 32'd0);
    realign();

    // Large steps must not wrap at either end.
    write(1'b1, {12'd0, 12'd0}, 1'b1, {8'd0, 8'd255});
    wait_pulse("down");
    check("down_data", 32'(out_data0), 32'h000000);
    realign();
    write(1'b1, {12'd0, 12'd4000}, 1'b1, 16'h0);
    wait_pulse("to4000");
    realign();
    write(1'b1, {12'd0, 12'd4095}, 1'b1, {8'd0, 8'd200});
    wait_pulse("up");
    check("up_data", 32'(out_data0), 32'h000FFF);
    realign();

    // Target write during CH1 waits for the next frame.
    wait_age(1);
    write(1'b1, {12'd0, 12'd3000}, 1'b1, 16'h0);
    wait_age(0);
    write(1'b1, {12'd0, 12'd50}, 1'b0, 16'h0);
    wait_pulse("ch1_old");
    check("ch1_old_data", 32'(out_data0), 32'h000BB8);
    realign();
    wait_pulse("ch1_new");
    check("ch1_new_data", 32'(out_data0), 32'h000032);
    realign();

    // Reset during CH2 aborts the frame.
    wait_age(1);
    write(1'b1, {12'd0, 12'd800}, 1'b0, 16'h0);
    wait_age(1);
    rst_n = 1'b0;
    #1;
    check("abort_wr",   32'(out_wr0),    32'd0);
    check("abort_data", 32'(out_data0),  32'h0);
    check("abort_at",   32'(at_target0), 32'b11);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_wr    = 1'b1;
    in_data  = {12'd0, 12'd800};
    realign();
    in_wr = 1'b0;
    n = 1;
    while (n < 3 * FD) begin
      @(negedge clk);
      if (out_wr0 === 1'b1) break;
      @(posedge clk);
      n++;
    end
    check("first_tick_latency", 32'(n), 32'd102);
    realign();

    // Randomized writes, some landing exactly on the tick.
    repeat (25 * FD) begin
      logic do_in, do_cfg;
      logic [15:0] st;
      do_in  = ($urandom_range(0, 39) == 0);
      do_cfg = ($urandom_range(0, 59) == 0);
      if (m_cnt == FD - 1 && $urandom_range(0, 2) == 0) begin
        do_in  = 1'b1;
        do_cfg = $urandom_range(0, 1) == 1;
      end
      st[7:0]  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      st[15:8] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      write(do_in, 24'($urandom), do_cfg, st);
    end

    repeat (8) realign();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
